// File: rtl/dma_pkg.sv
// Shared DMA read-side definitions: arbiter FSM encodings and constants
// common to the read arbiter and the DMA read-stream controller.
package dma_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_BUSY  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // 64-byte block stride and the controller's minimum gap between streams
  localparam int DMA_BLK_SHIFT    = 6;
  localparam int RD_RESTART_DELAY = 3;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/dma_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from
// ptr, wrapping modulo NUM_REQ. Shared by read and future write arbiters.
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int k;

  // Scan from the farthest offset down so the nearest hit overwrites the rest
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = 0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      k = (int'(ptr) + off) % NUM_REQ;
      if (req[k]) begin
        gnt    = '0;
        gnt[k] = 1'b1;
        idx    = IDX_W'(k);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_rd_arbiter.sv
// Round-robin owner of the single DMA read-stream controller: grants one
// loader, launches its stream, waits for completion, returns a done pulse.
module dma_rd_arbiter
  import dma_pkg::*;
#(
  parameter int  NUM_REQ      = 3,
  parameter int  AXI_WIDTH_AD = 32,
  parameter int  BIT_TRANS    = 18,
  localparam int IDX_W        = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [NUM_REQ-1:0]              i_req,
  input  logic [NUM_REQ*AXI_WIDTH_AD-1:0] i_base_addr,
  input  logic [NUM_REQ*BIT_TRANS-1:0]    i_num_trans,
  input  logic [NUM_REQ*16-1:0]           i_num_blk,
  output logic [NUM_REQ-1:0]              o_done,
  output logic [NUM_REQ-1:0]              o_grant,
  output logic [IDX_W-1:0]                o_owner_idx,
  output logic                            o_busy,
  output logic                            o_dma_rd_start,
  output logic [AXI_WIDTH_AD-1:0]         o_dma_base_addr,
  output logic [BIT_TRANS-1:0]            o_dma_num_trans,
  output logic [15:0]                     o_dma_max_blk,
  input  logic                            i_dma_rd_done
);

  logic [1:0]              state_reg;
  logic [IDX_W-1:0]        rr_ptr_reg;
  logic [IDX_W-1:0]        owner_idx_reg;
  logic [NUM_REQ-1:0]      grant_reg;
  logic [NUM_REQ-1:0]      done_reg;
  logic                    busy_reg;
  logic                    start_reg;
  logic [AXI_WIDTH_AD-1:0] base_reg;
  logic [BIT_TRANS-1:0]    trans_reg;
  logic [15:0]             blk_reg;

  logic [NUM_REQ-1:0]      pick_gnt;
  logic [IDX_W-1:0]        pick_idx;
  logic                    pick_any;

  logic [AXI_WIDTH_AD-1:0] base_arr  [NUM_REQ];
  logic [BIT_TRANS-1:0]    trans_arr [NUM_REQ];
  logic [15:0]             blk_arr   [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
      assign base_arr[gi]  = i_base_addr[gi*AXI_WIDTH_AD +: AXI_WIDTH_AD];
      assign trans_arr[gi] = i_num_trans[gi*BIT_TRANS +: BIT_TRANS];
      assign blk_arr[gi]   = i_num_blk[gi*16 +: 16];
    end
  endgenerate

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req (i_req),
    .ptr (rr_ptr_reg),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= ST_IDLE;
      rr_ptr_reg    <= '0;
      owner_idx_reg <= '0;
      grant_reg     <= '0;
      done_reg      <= '0;
      busy_reg      <= 1'b0;
      start_reg     <= 1'b0;
      base_reg      <= '0;
      trans_reg     <= '0;
      blk_reg       <= '0;
    end else begin
      done_reg  <= '0;
      start_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (pick_any) begin
            grant_reg     <= pick_gnt;
            owner_idx_reg <= pick_idx;
            busy_reg      <= 1'b1;
            base_reg      <= base_arr[pick_idx];
            trans_reg     <= trans_arr[pick_idx];
            blk_reg       <= blk_arr[pick_idx];
            // A zero block count would wrap the controller's count-1 compare
            if (blk_arr[pick_idx] == '0) begin
              state_reg <= ST_DONE;
              done_reg  <= pick_gnt;
            end else begin
              state_reg <= ST_START;
              start_reg <= 1'b1;
            end
          end
        end
        ST_START: state_reg <= ST_BUSY;
        ST_BUSY: begin
          if (i_dma_rd_done) begin
            state_reg <= ST_DONE;
            done_reg  <= grant_reg;
          end
        end
        ST_DONE: begin
          state_reg     <= ST_IDLE;
          grant_reg     <= '0;
          busy_reg      <= 1'b0;
          owner_idx_reg <= '0;
          rr_ptr_reg    <= IDX_W'(rr_next(int'(owner_idx_reg), NUM_REQ));
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign o_done          = done_reg;
  assign o_grant         = grant_reg;
  assign o_owner_idx     = owner_idx_reg;
  assign o_busy          = busy_reg;
  assign o_dma_rd_start  = start_reg;
  assign o_dma_base_addr = base_reg;
  assign o_dma_num_trans = trans_reg;
  assign o_dma_max_blk   = blk_reg;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rstn) begin
      assert (!(i_dma_rd_done && state_reg != ST_BUSY))
        else $warning("i_dma_rd_done ignored outside BUSY");
    end
  end
`endif

endmodule

// File: doc/dma_rd_arbiter.md
Name: dma_rd_arbiter

Overview:
Round-robin scheduler that shares the single DMA read-stream controller among NUM_REQ loaders (ifmap, weight, bias/scale).
- Each requester posts a stream descriptor: base address, beats per block, block count.
- The arbiter grants one requester, launches the stream, and waits for stream-done. It then returns a one-cycle done to the owner and rotates priority.
- It also exports the owner index so the read-data path can steer returned beats to the right buffer.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
AXI_WIDTH_AD, 32, DRAM byte address width
BIT_TRANS, 18, width of per-block beat count
IDX_W, $clog2(NUM_REQ), width of owner index (derived, not overridden)

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
i_req  in  NUM_REQ  per-requester stream request, level, held until matching o_done
i_base_addr  in  NUM_REQ*AXI_WIDTH_AD  packed base addresses, slot k at [k*AXI_WIDTH_AD +: AXI_WIDTH_AD]
i_num_trans  in  NUM_REQ*BIT_TRANS  packed beats per block
i_num_blk  in  NUM_REQ*16  packed block counts
o_done  out  NUM_REQ  one-cycle pulse: requester k's stream finished
o_grant  out  NUM_REQ  one-hot current owner, 0 when idle
o_owner_idx  out  IDX_W  binary owner index, valid while o_busy
o_busy  out  1  a stream is granted and not yet completed
o_dma_rd_start  out  1  one-cycle stream start to DMA read controller
o_dma_base_addr  out  AXI_WIDTH_AD  latched base address of owner
o_dma_num_trans  out  BIT_TRANS  latched beats per block
o_dma_max_blk  out  16  latched block count
i_dma_rd_done  in  1  one-cycle stream-done from DMA read controller

Behaviour:
- Reset: all outputs 0; FSM = IDLE; rr pointer = 0; latched descriptor = 0. Reset mid-stream aborts ownership immediately. No o_done is issued for the aborted stream, and requesters must re-request.
- FSM states: IDLE, START, BUSY, DONE.
- IDLE:
  - If any i_req, pick the winner: the first set bit scanning from the rr pointer upward, wrapping modulo NUM_REQ.
  - Register owner index and one-hot grant. Latch slot fields into o_dma_base_addr, o_dma_num_trans, o_dma_max_blk.
  - Next state is START, or DONE if the latched block count is 0.
  - If no request, stay in IDLE.
- START: o_dma_rd_start=1 for exactly this cycle; next state is BUSY.
- BUSY: hold all o_dma_* outputs stable. On i_dma_rd_done go to DONE, otherwise stay.
- DONE:
  - o_done[owner]=1 for this cycle only.
  - rr pointer = owner+1, wrapping to 0 at NUM_REQ.
  - Clear o_grant and o_busy on the transition to IDLE.
  - Next state is IDLE.
- o_busy=1 in START, BUSY and DONE. o_grant and o_owner_idx are valid over the same window.
- Latency:
  - Request sampled in IDLE at cycle N gives start at cycle N+1.
  - Done seen at cycle M gives o_done at M+1 and IDLE at M+2.
  - The earliest next start is therefore M+3.
- Zero-block descriptor (num_blk==0): never start DMA, because the controller's count-1 compare would wrap. Path is IDLE→DONE and o_done pulses one cycle after the grant.
- i_req dropped before grant: ignored, no done. i_req dropped after grant: stream still completes and o_done still pulses.
- Requester re-asserts i_req in the cycle after its o_done: it is treated as a fresh request at lowest priority.
- i_dma_rd_done outside BUSY: ignored, with no state change. A simulation-only assertion flags it.
- Descriptor inputs are sampled only in the grant cycle. Later changes do not affect the running stream.
- Only one stream is in flight at any time; there is no pipelining of grant.

Decomposition:
- Shared package (dma_pkg): state encodings, and constants DMA_BLK_SHIFT=6 (64-byte block stride) and RD_RESTART_DELAY=3, used by both this block and the DMA controller.
- One sub-module, rr_pick, holds the combinational round-robin priority picker.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, index, any.
  - It is reusable for a future write-side arbiter.

Test Plan:
1. Single request: i_req=3'b010, base=0x1000_0000, trans=16, blk=4 → start 1 cycle later; o_dma_base_addr=0x1000_0000 and o_dma_max_blk=4 held. Done pulse → o_done=3'b010 next cycle, o_busy drops one cycle after that.
2. Fairness: all three i_req high continuously with done returned after 10 cycles each → grant order 0,1,2,0,1,2. Each o_done is exactly one cycle wide.
3. Rotation skip: pointer=1 after serving 0; i_req=3'b001 only → requester 0 is granted, wrapping past empty slots 1 and 2.
4. Zero-block: slot 2 blk=0 → o_dma_rd_start never asserts; o_done[2] pulses one cycle after grant; then slot 0 is served normally.
5. Descriptor stability: change i_base_addr[0] to 0x2000_0000 during BUSY → o_dma_base_addr stays at the original value until DONE.
6. Reset and spurious done: rstn low during BUSY → all outputs 0 and no o_done. After reset, i_dma_rd_done pulses while in IDLE → no state change and o_done stays 0.
